fir_mac_engine: RTL and testbench

Sequential multiply-accumulate FIR engine that consumes coefficients from the tap ROM. It issues tap indices to the ROM and multiplies each returned tap (one-cycle read latency) by the matching delayed sample. It accumulates one output per input sample, then rounds and saturates the result to Q1.15. Input and output are both valid/ready streams; the block is the processing core between the sample source and the downstream sink.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_mac_engine_if.sv | 26 ++
 rtl/fir_sample_ring.sv | 52 +++++
 rtl/fir_mac_engine.sv | 119 +++++++++++
 tb/tb_fir_mac_engine.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, FSM states and Q1.15 round/saturate helper for the FIR MAC engine
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int IDX_WIDTH  = 7;
  // Widest accumulator any legal tap count can need (128 taps)
  localparam int ACC_MAX    = 2 * DATA_WIDTH + IDX_WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} fir_state_e;

  // Full-precision products plus enough guard bits to sum n_taps of them
  function automatic int acc_width(input int n_taps);
    return 2 * DATA_WIDTH + $clog2(n_taps);
  endfunction

  // Round half up at the Q1.15 point, then clamp to the signed 16-bit range
  function automatic logic [DATA_WIDTH-1:0] sat_round_q15(input logic signed [ACC_MAX-1:0] acc);
    logic signed [ACC_MAX:0] sum;
    logic signed [ACC_MAX:0] hi;
    logic signed [ACC_MAX:0] lo;
    hi  = (ACC_MAX+1)'(2 ** (DATA_WIDTH - 1) - 1);
    lo  = ~hi;
    sum = (ACC_MAX+1)'(acc) + (ACC_MAX+1)'(2 ** (DATA_WIDTH - 2));
    sum = sum >>> (DATA_WIDTH - 1);
    if (sum > hi) begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sum < lo) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    return sum[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// rtl/fir_mac_engine_if.sv - sample stream, tap ROM port and result stream of the FIR MAC engine
interface fir_mac_engine_if;
  import fir_pkg::*;

  logic [DATA_WIDTH-1:0] i_sample;
  logic                  i_valid;
  logic                  o_ready;
  logic [IDX_WIDTH-1:0]  o_idx;
  logic [DATA_WIDTH-1:0] i_tap;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_valid;
  logic                  i_ready;

  // Engine side
  modport slave (
    input  i_sample, i_valid, i_tap, i_ready,
    output o_ready, o_idx, o_result, o_valid
  );

  // Source, ROM and sink side
  modport master (
    output i_sample, i_valid, i_tap, i_ready,
    input  o_ready, o_idx, o_result, o_valid
  );

endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - delay line of the last N_TAPS samples with registered read k back from newest
module fir_sample_ring #(
  parameter int N_TAPS     = 16,
  parameter int DATA_WIDTH = 16,
  parameter int PTR_W      = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [PTR_W-1:0]      rd_off,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [PTR_W:0]   N_EXT = (PTR_W+1)'(N_TAPS);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_TAPS - 1);

  logic [DATA_WIDTH-1:0] mem [N_TAPS];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        rd_sum;
  logic [PTR_W-1:0]      rd_addr;

  // newest - k modulo N_TAPS; newest sits one behind wr_ptr, bias by N to stay non-negative
  always_comb begin
    rd_sum = {1'b0, wr_ptr} + N_EXT - (PTR_W+1)'(1) - {1'b0, rd_off};
    if (rd_sum >= N_EXT) begin
      rd_sum = rd_sum - N_EXT;
    end
    rd_addr = rd_sum[PTR_W-1:0];
  end

  // Sample storage, wrapping write pointer and read register; reset zeroes history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - sequential MAC FIR core: one sample in, N_TAPS ROM-driven MACs, one Q1.15 result out
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int N_TAPS = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fir_mac_engine_if.slave bus
);

  localparam int ACC_WIDTH = acc_width(N_TAPS);
  localparam int PTR_W     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(N_TAPS - 1);

  fir_state_e                   state;
  fir_state_e                   state_next;
  logic                         run_q;
  logic                         accept;
  logic [IDX_WIDTH-1:0]         k;
  logic                         mac_q;
  logic [DATA_WIDTH-1:0]        dsample;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic [DATA_WIDTH-1:0]        result_q;

  // Handshake only once out of reset and idle; run_q holds o_ready low the first cycle
  assign accept = (state == IDLE) && run_q && bus.i_valid;

  fir_sample_ring #(
    .N_TAPS     (N_TAPS),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_W      (PTR_W)
  ) u_ring (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (accept),
    .wr_data (bus.i_sample),
    .rd_en   (state == MAC),
    .rd_off  (k[PTR_W-1:0]),
    .rd_data (dsample)
  );

  // Tap and delayed sample both arrive one cycle after the index was issued
  assign product  = $signed(bus.i_tap) * $signed(dsample);
  assign acc_next = acc + (mac_q ? ACC_WIDTH'(product) : '0);
  assign bus.o_result = result_q;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/index outputs
  always_comb begin
    state_next  = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_idx   = '0;
    unique case (state)
      IDLE: begin
        bus.o_ready = run_q;
        if (accept) begin
          state_next = MAC;
        end
      end
      MAC: begin
        bus.o_idx = k;
        if (k == K_LAST) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = OUT;
      end
      OUT: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tap counter, product-valid pipe, accumulator and result register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q    <= 1'b0;
      k        <= '0;
      mac_q    <= 1'b0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      run_q <= 1'b1;
      mac_q <= (state == MAC);
      if (accept) begin
        k   <= '0;
        acc <= '0;
      end else begin
        acc <= acc_next;
        if (state == MAC) begin
          k <= k + IDX_WIDTH'(1);
        end
      end
      if (state == DRAIN) begin
        result_q <= sat_round_q15(ACC_MAX'(acc_next));
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - scoreboard bench for fir_mac_engine with a 16-tap ROM model
module tb_fir_mac_engine;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_engine_if bus();

  fir_mac_engine #(.N_TAPS(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic signed [15:0] taps [16] = '{
    16'h0565, 16'h0BD9, 16'h0B0B, 16'hFF27, 16'hF3A7, 16'hFB52, 16'h182E, 16'h3384,
    16'h3384, 16'h182E, 16'hFB52, 16'hF3A7, 16'hFF27, 16'h0B0B, 16'h0BD9, 16'h0565};

  // Coefficient ROM with one-cycle read latency
  always @(posedge clk) bus.i_tap <= taps[bus.o_idx[3:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q [$];
  logic signed [15:0] hist [16];
  int wp;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) hist[i] = 16'sd0;
    wp = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [15:0] s);
    longint sum;
    longint r;
    hist[wp] = s;
    wp = (wp + 1) % 16;
    sum = 0;
    for (int k = 0; k < 16; k++)
      sum += longint'(hist[(wp - 1 - k + 32) % 16]) * longint'(taps[k]);
    r = (sum + 16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    exp_q.push_back(r[15:0]);
  endtask

  function automatic logic [15:0] pop_exp();
    logic [15:0] e;
    e = 16'hxxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: o_ready=%0b after %0d cycles, required 1", bus.o_ready, n);
    end
    bus.i_sample = s;
    bus.i_valid  = 1'b1;
    model_push(s);
    @(negedge clk);
    accept_cyc = cyc;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] r, output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = bus.o_result;
  endtask

  task automatic test_reset();
    logic [15:0] r, e;
    int lat;
    rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b required 0", bus.o_ready); end
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b required 0", bus.o_valid); end
    if (bus.o_result !== 16'h0) begin errors++; $display("FAIL rst_result: got %h required 0000", bus.o_result); end
    if (bus.o_idx !== 7'h0) begin errors++; $display("FAIL rst_idx: got %h required 00", bus.o_idx); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %0b required 0", bus.o_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %0b required 1", bus.o_ready); end
    // Reset while sitting in OUT with a result on the bus
    bus.i_ready = 1'b0;
    send(16'h7FFF);
    wait_out(r, lat);
    e = pop_exp();
    checks++;
    if (r !== e) begin errors++; $display("FAIL rst_pre_result: got %h required %h", r, e); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", bus.o_valid); end
    if (bus.o_result !== 16'h0) begin errors++; $display("FAIL rst_out_result: got %h required 0000", bus.o_result); end
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL rst_out_ready: got %0b required 0", bus.o_ready); end
    if (bus.o_idx !== 7'h0) begin errors++; $display("FAIL rst_out_idx: got %h required 00", bus.o_idx); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    bus.i_ready = 1'b1;
  endtask

  task automatic test_impulse();
    logic [15:0] r, e;
    int lat;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(i == 0 ? 16'h7FFF : 16'h0000);
      wait_out(r, lat);
      e = pop_exp();
      checks += 3;
      if (r !== e) begin errors++; $display("FAIL impulse_model[%0d]: got %h required %h", i, r, e); end
      if (r !== taps[i]) begin errors++; $display("FAIL impulse_tap[%0d]: got %h required %h", i, r, taps[i]); end
      if (lat != 18) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d required 18", i, lat); end
    end
  endtask

  task automatic test_step(input logic [15:0] v, input logic [15:0] final_exp);
    logic [15:0] r, e;
    int lat;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(v);
      wait_out(r, lat);
      e = pop_exp();
      checks++;
      if (r !== e) begin errors++; $display("FAIL step_%h[%0d]: got %h required %h", v, i, r, e); end
      if (i == 15) begin
        checks += 2;
        if (r !== final_exp) begin errors++; $display("FAIL step_%h_final: got %h required %h", v, r, final_exp); end
        if (lat != 18) begin errors++; $display("FAIL step_%h_latency: got %0d required 18", v, lat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r, e, s;
    int lat, prev;
    do_reset();
    bus.i_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      s = 16'($urandom);
      send(s);
      if (i > 0) begin
        checks++;
        if (accept_cyc - prev != 19) begin errors++; $display("FAIL b2b_period[%0d]: got %0d required 19", i, accept_cyc - prev); end
      end
      prev = accept_cyc;
      wait_out(r, lat);
      e = pop_exp();
      checks++;
      if (r !== e) begin errors++; $display("FAIL b2b_result[%0d]: got %h required %h (sample %h)", i, r, e, s); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] r, first, e;
    int lat;
    do_reset();
    bus.i_ready = 1'b0;
    send(16'h7FFF);
    wait_out(first, lat);
    e = pop_exp();
    checks++;
    if (first !== e) begin errors++; $display("FAIL bp_first: got %h required %h", first, e); end
    bus.i_sample = 16'h1234;
    bus.i_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %0b required 1", i, bus.o_valid); end
      if (bus.o_result !== first) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h required %h", i, bus.o_result, first); end
      if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %0b required 0", i, bus.o_ready); end
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b required 0", bus.o_valid); end
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b required 1", bus.o_ready); end
    model_push(16'h1234);
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_out(r, lat);
    e = pop_exp();
    checks += 2;
    if (r !== e) begin errors++; $display("FAIL bp_pending_result: got %h required %h", r, e); end
    if (lat != 18) begin errors++; $display("FAIL bp_pending_latency: got %0d required 18", lat); end
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] r, e;
    int lat, seen;
    do_reset();
    send(16'h4000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.o_idx !== 7'h0) begin errors++; $display("FAIL midmac_idx: got %h required 00", bus.o_idx); end
    if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL midmac_ready: got %0b required 0", bus.o_ready); end
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midmac_valid: got %0b required 0", bus.o_valid); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midmac_no_output: got %0d valid cycles required 0", seen); end
    send(16'h7FFF);
    wait_out(r, lat);
    e = pop_exp();
    checks += 3;
    if (r !== e) begin errors++; $display("FAIL midmac_post_model: got %h required %h", r, e); end
    if (r !== 16'h0565) begin errors++; $display("FAIL midmac_post_result: got %h required 0565", r); end
    if (lat != 18) begin errors++; $display("FAIL midmac_post_latency: got %0d required 18", lat); end
  endtask

  initial begin
    bus.i_sample = '0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;
    test_reset();
    test_impulse();
    test_step(16'h4000, 16'h561B);
    test_step(16'h7FFF, 16'h7FFF);
    test_step(16'h8000, 16'h8000);
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
